// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the PC sequencer
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

  localparam int ILEN_COMPRESSED = 2;
  localparam int ILEN_FULL       = 4;

  function automatic logic pc_ilen_legal(input int ilen);
    return (ilen == ILEN_COMPRESSED) || (ilen == ILEN_FULL);
  endfunction

  // Only the low address bits matter for 2- or 4-byte alignment.
  function automatic logic pc_misaligned(input logic [1:0] addr_lo, input int ilen);
    return (ilen == ILEN_COMPRESSED) ? addr_lo[0] : (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority next-PC/next-state selection with misalign check
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                XLEN        = 64,
  parameter logic [XLEN-1:0]   TRAP_VECTOR = XLEN'('h100),
  parameter int                ILEN_BYTES  = 4
) (
  input  pc_state_e            state_i,
  input  logic                 stall_i,
  input  logic                 jump_i,
  input  logic [XLEN-1:0]      jump_target_i,
  input  logic                 branch_taken_i,
  input  logic [XLEN-1:0]      branch_target_i,
  input  logic                 trap_req_i,
  input  logic                 mret_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      epc_i,
  output logic [XLEN-1:0]      pc_next_o,
  output pc_state_e            state_next_o,
  output logic                 epc_load_o,
  output logic                 misalign_o,
  output logic                 advance_o
);

  localparam int ILEN_EFF = pc_ilen_legal(ILEN_BYTES) ? ILEN_BYTES : ILEN_FULL;

  logic [XLEN-1:0] redirect_target;
  logic            redirect_bad;

  assign redirect_target = jump_i ? jump_target_i : branch_target_i;
  assign redirect_bad    = pc_misaligned(redirect_target[1:0], ILEN_EFF);

  always_comb begin
    pc_next_o    = pc_i;
    state_next_o = state_i;
    epc_load_o   = 1'b0;
    misalign_o   = 1'b0;
    advance_o    = 1'b0;
    unique case (state_i)
      ST_BOOT: state_next_o = ST_RUN;
      ST_HALT: state_next_o = ST_HALT;
      default: begin
        if (!stall_i) begin
          advance_o = 1'b1;
          if (trap_req_i) begin
            if (state_i == ST_RUN) begin
              epc_load_o   = 1'b1;
              pc_next_o    = TRAP_VECTOR;
              state_next_o = ST_TRAP;
            end else begin
              state_next_o = ST_HALT;
            end
          end else if (mret_i && state_i == ST_TRAP) begin
            pc_next_o    = epc_i;
            state_next_o = ST_RUN;
          end else if (jump_i || branch_taken_i) begin
            if (!redirect_bad) begin
              pc_next_o = redirect_target;
            end else if (state_i == ST_RUN) begin
              epc_load_o   = 1'b1;
              misalign_o   = 1'b1;
              pc_next_o    = TRAP_VECTOR;
              state_next_o = ST_TRAP;
            end else begin
              state_next_o = ST_HALT;
            end
          end else begin
            pc_next_o = pc_i + XLEN'(ILEN_EFF);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with boot, trap/return FSM and retire counter
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              ILEN_BYTES   = 4,
  parameter int              CNT_W        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [XLEN-1:0]   jump_target,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              trap_req,
  input  logic              mret,
  output logic [XLEN-1:0]   pc_out,
  output logic              pc_valid,
  output logic [XLEN-1:0]   epc_out,
  output logic              in_trap,
  output logic              halted,
  output logic              misalign_trap,
  output logic [CNT_W-1:0]  instret
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q;
  logic [CNT_W-1:0] instret_q;
  logic             misalign_q, pc_valid_q, in_trap_q, halted_q;
  logic             epc_load, misalign_d, advance;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ILEN_BYTES  (ILEN_BYTES)
  ) u_next_sel (
    .state_i         (state_q),
    .stall_i         (stall),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .trap_req_i      (trap_req),
    .mret_i          (mret),
    .pc_i            (pc_q),
    .epc_i           (epc_q),
    .pc_next_o       (pc_d),
    .state_next_o    (state_d),
    .epc_load_o      (epc_load),
    .misalign_o      (misalign_d),
    .advance_o       (advance)
  );

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      instret_q  <= '0;
      misalign_q <= 1'b0;
      pc_valid_q <= 1'b0;
      in_trap_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      pc_valid_q <= (state_d == ST_RUN) || (state_d == ST_TRAP);
      in_trap_q  <= (state_d == ST_TRAP);
      halted_q   <= (state_d == ST_HALT);
      if (epc_load) epc_q <= pc_q;
      if (advance)  instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign pc_out        = pc_q;
  assign pc_valid      = pc_valid_q;
  assign epc_out       = epc_q;
  assign in_trap       = in_trap_q;
  assign halted        = halted_q;
  assign misalign_trap = misalign_q;
  assign instret       = instret_q;

endmodule
